// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Used by hazard_stall_unit, muldiv_busy_tracker and the pipeline-side interface.
package hazard_pkg;

  // Mult/div busy-tracker states
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Default mult/div latencies (EX issue to HI/LO valid)
  localparam int DEF_MULT_CYCLES = 4;
  localparam int DEF_DIV_CYCLES  = 32;

  // Architectural $zero never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a producer register feeds either source of the ID instruction
  function automatic logic reg_match(input logic [4:0] wreg,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (wreg != REG_ZERO) && ((wreg == rs) || (wreg == rt));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle of pipeline hazard inputs and interlock outputs.
// master: pipeline datapath/control side; slave: hazard_stall_unit.
interface hazard_stall_unit_if;
  logic [4:0] Rs_ID;
  logic [4:0] Rt_ID;
  logic [4:0] writereg_EX;
  logic [4:0] writereg_M;
  logic       RegWrite_EX;
  logic       MemtoReg_EX;
  logic       MemtoReg_M;
  logic       BranchD;
  logic       PCSrcD;
  logic       HiLoRead_ID;
  logic       MulDivStart_ID;
  logic       MulDivStart_EX;
  logic       MulDivIsDiv_EX;
  logic       StallF;
  logic       StallD;
  logic       FlushE;
  logic       FlushD;
  logic       muldiv_busy;
  logic       muldiv_done;

  modport master (
    output Rs_ID, Rt_ID, writereg_EX, writereg_M, RegWrite_EX, MemtoReg_EX,
           MemtoReg_M, BranchD, PCSrcD, HiLoRead_ID, MulDivStart_ID,
           MulDivStart_EX, MulDivIsDiv_EX,
    input  StallF, StallD, FlushE, FlushD, muldiv_busy, muldiv_done
  );

  modport slave (
    input  Rs_ID, Rt_ID, writereg_EX, writereg_M, RegWrite_EX, MemtoReg_EX,
           MemtoReg_M, BranchD, PCSrcD, HiLoRead_ID, MulDivStart_ID,
           MulDivStart_EX, MulDivIsDiv_EX,
    output StallF, StallD, FlushE, FlushD, muldiv_busy, muldiv_done
  );
endinterface

// File: rtl/muldiv_busy_tracker.sv
// Models the iterative mult/div unit: goes BUSY for the selected latency
// after an issue, then pulses done for one cycle as it returns to IDLE.
// A start seen while BUSY is ignored (the counter is not reloaded).
module muldiv_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state, counter and done-pulse logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = is_div_i ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and done registers; reset aborts any tracked operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = done_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock controller for the 5-stage MIPS pipeline: load-use,
// ID-stage branch operand and HI/LO-behind-mult/div hazards.
// Optional feature macro: HAZARD_MULDIV_EN enables mult/div busy tracking;
// without it the unit is purely combinational and the muldiv outputs are 0.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_unit_if.slave   hz
);

  logic lwstall_s;
  logic branchstall_s;
  logic mdstall_s;
  logic stall_s;
  logic busy_s;
  logic done_s;

`ifdef HAZARD_MULDIV_EN
  muldiv_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (hz.MulDivStart_EX),
    .is_div_i (hz.MulDivIsDiv_EX),
    .busy_o   (busy_s),
    .done_o   (done_s)
  );

  // HI/LO reads and new mult/div wait while the unit is busy or being issued
  always_comb begin
    mdstall_s = 1'b0;
    if (hz.HiLoRead_ID || hz.MulDivStart_ID) begin
      mdstall_s = busy_s || hz.MulDivStart_EX;
    end else begin
      mdstall_s = 1'b0;
    end
  end
`else
  logic unused_md_s;
  localparam int UNUSED_CFG = MULT_CYCLES + DIV_CYCLES;

  assign unused_md_s = ^{clk, rst_n, hz.HiLoRead_ID, hz.MulDivStart_ID,
                         hz.MulDivStart_EX, hz.MulDivIsDiv_EX,
                         (UNUSED_CFG != 0)};
  assign busy_s = 1'b0;
  assign done_s = 1'b0;

  // Mult/div tracking is compiled out, so it never stalls
  always_comb begin
    mdstall_s = 1'b0;
  end
`endif

  // Data hazards forwarding cannot cover, combined into one interlock
  always_comb begin
    lwstall_s     = hz.MemtoReg_EX &&
                    reg_match(hz.writereg_EX, hz.Rs_ID, hz.Rt_ID);
    branchstall_s = 1'b0;
    if (hz.BranchD) begin
      branchstall_s =
        (hz.RegWrite_EX && reg_match(hz.writereg_EX, hz.Rs_ID, hz.Rt_ID)) ||
        (hz.MemtoReg_M  && reg_match(hz.writereg_M,  hz.Rs_ID, hz.Rt_ID));
    end else begin
      branchstall_s = 1'b0;
    end
    stall_s = lwstall_s || branchstall_s || mdstall_s;
  end

  assign hz.StallF      = stall_s;
  assign hz.StallD      = stall_s;
  assign hz.FlushE      = stall_s;
  // A stalled branch must not squash the fetch until it actually resolves
  assign hz.FlushD      = hz.PCSrcD && !stall_s;
  assign hz.muldiv_busy = busy_s;
  assign hz.muldiv_done = done_s;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed test-plan sequences and
// random traffic, checked against a cycle-indexed reference model.
module tb_hazard_stall_unit;
  import hazard_pkg::*;

  localparam int MC = 4;
  localparam int DC = 32;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs, rt, wex, wm;
    logic       regwrite_ex, m2r_ex, m2r_m, branch, pcsrc;
    logic       hilo, mdstart_id, mdstart_ex, isdiv;
  } stim_t;

  typedef struct {
    int   cyc;
    logic stall, flushd, busy, done;
  } exp_t;

  logic clk;
  logic rst_n;
  hazard_stall_unit_if hz();

  hazard_stall_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // Reference model: an accepted issue at cycle c keeps the unit busy for
  // cycles c+1..c+N and makes HI/LO valid in cycle c+N+1.
  int busy_start = -100;
  int busy_end   = -100;
  int done_at    = -100;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst_n = 1'b1; s.rs = 5'd0; s.rt = 5'd0; s.wex = 5'd0; s.wm = 5'd0;
    s.regwrite_ex = 1'b0; s.m2r_ex = 1'b0; s.m2r_m = 1'b0; s.branch = 1'b0;
    s.pcsrc = 1'b0; s.hilo = 1'b0; s.mdstart_id = 1'b0; s.mdstart_ex = 1'b0;
    s.isdiv = 1'b0;
    return s;
  endfunction

  function automatic bit dep(logic [4:0] w, logic [4:0] rs, logic [4:0] rt);
    return (w != 5'd0) && (w == rs || w == rt);
  endfunction

  task automatic cycle(input stim_t s);
    exp_t e;
    bit   lw, br, md, busy;
    @(posedge clk);
    #1;
    cyc++;
    rst_n             = s.rst_n;
    hz.Rs_ID          = s.rs;
    hz.Rt_ID          = s.rt;
    hz.writereg_EX    = s.wex;
    hz.writereg_M     = s.wm;
    hz.RegWrite_EX    = s.regwrite_ex;
    hz.MemtoReg_EX    = s.m2r_ex;
    hz.MemtoReg_M     = s.m2r_m;
    hz.BranchD        = s.branch;
    hz.PCSrcD         = s.pcsrc;
    hz.HiLoRead_ID    = s.hilo;
    hz.MulDivStart_ID = s.mdstart_id;
    hz.MulDivStart_EX = s.mdstart_ex;
    hz.MulDivIsDiv_EX = s.isdiv;
    if (!s.rst_n) begin
      busy_start = -100; busy_end = -100; done_at = -100;
    end
    busy = MD_EN && s.rst_n && (cyc > busy_start) && (cyc <= busy_end);
    lw = s.m2r_ex && dep(s.wex, s.rs, s.rt);
    br = s.branch && ((s.regwrite_ex && dep(s.wex, s.rs, s.rt)) ||
                      (s.m2r_m && dep(s.wm, s.rs, s.rt)));
    md = MD_EN && (s.hilo || s.mdstart_id) && (busy || s.mdstart_ex);
    e.cyc    = cyc;
    e.stall  = lw | br | md;
    e.flushd = s.pcsrc && !(lw | br | md);
    e.busy   = busy;
    e.done   = MD_EN && s.rst_n && (cyc == done_at);
    if (MD_EN && s.rst_n && s.mdstart_ex && !busy) begin
      busy_start = cyc;
      busy_end   = cyc + (s.isdiv ? DC : MC);
      done_at    = busy_end + 1;
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int c, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
    end
  endtask

  // Monitor: compare each presented cycle's outputs with the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("StallF",      e.cyc, hz.StallF,      e.stall);
      chk("StallD",      e.cyc, hz.StallD,      e.stall);
      chk("FlushE",      e.cyc, hz.FlushE,      e.stall);
      chk("FlushD",      e.cyc, hz.FlushD,      e.flushd);
      chk("muldiv_busy", e.cyc, hz.muldiv_busy, e.busy);
      chk("muldiv_done", e.cyc, hz.muldiv_done, e.done);
    end
  end

  initial begin
    stim_t s;
    int    guard;
    rst_n = 1'b0;
    s = idle_stim();
    s.rst_n = 1'b0;
    repeat (3) cycle(s);

    // Load-use: lw $8 in EX, add using $8 in ID, then the bubble
    s = idle_stim(); s.m2r_ex = 1'b1; s.regwrite_ex = 1'b1; s.wex = 5'd8; s.rs = 5'd8;
    cycle(s);
    s = idle_stim(); s.rs = 5'd8; s.wm = 5'd8; s.m2r_m = 1'b1;
    cycle(s);

    // Branch behind load to $9, then to $0 (no stall)
    for (int z = 0; z < 2; z++) begin
      s = idle_stim(); s.branch = 1'b1; s.rs = (z == 0) ? 5'd9 : 5'd0;
      s.m2r_ex = 1'b1; s.regwrite_ex = 1'b1; s.wex = s.rs;
      cycle(s);
      s = idle_stim(); s.branch = 1'b1; s.rs = (z == 0) ? 5'd9 : 5'd0;
      s.m2r_m = 1'b1; s.wm = s.rs;
      cycle(s);
      s = idle_stim(); s.branch = 1'b1; s.rs = (z == 0) ? 5'd9 : 5'd0; s.pcsrc = 1'b1;
      cycle(s);
    end
    // Branch behind ALU writer to $9, with taken-branch attempt during stall
    s = idle_stim(); s.branch = 1'b1; s.rt = 5'd9; s.regwrite_ex = 1'b1; s.wex = 5'd9;
    s.pcsrc = 1'b1;
    cycle(s);
    s = idle_stim(); s.branch = 1'b1; s.rt = 5'd9; s.pcsrc = 1'b1;
    cycle(s);

    // Divide then multiply with mflo waiting in ID
    for (int k = 0; k < 2; k++) begin
      s = idle_stim(); s.mdstart_ex = 1'b1; s.isdiv = (k == 0); s.hilo = 1'b1;
      cycle(s);
      s = idle_stim(); s.hilo = 1'b1;
      repeat ((k == 0) ? DC + 2 : MC + 2) cycle(s);
    end

    // Back-to-back mult: second one held in ID, issued in the done cycle
    s = idle_stim(); s.mdstart_ex = 1'b1;
    cycle(s);
    s = idle_stim(); s.mdstart_id = 1'b1;
    repeat (MC) cycle(s);
    s = idle_stim(); s.mdstart_ex = 1'b1;
    cycle(s);
    s = idle_stim();
    repeat (MC + 3) cycle(s);

    // Reset asserted in the 10th busy cycle of a divide
    s = idle_stim(); s.mdstart_ex = 1'b1; s.isdiv = 1'b1;
    cycle(s);
    s = idle_stim();
    repeat (9) cycle(s);
    s.rst_n = 1'b0;
    repeat (2) cycle(s);
    s = idle_stim();
    repeat (DC + 4) cycle(s);

    // Random traffic over a small register set to make hazards frequent
    for (int i = 0; i < 3000; i++) begin
      s.rst_n       = ($urandom_range(0, 299) != 0);
      s.rs          = 5'($urandom_range(0, 3));
      s.rt          = 5'($urandom_range(0, 3));
      s.wex         = 5'($urandom_range(0, 3));
      s.wm          = 5'($urandom_range(0, 3));
      s.regwrite_ex = 1'($urandom_range(0, 1));
      s.m2r_ex      = 1'($urandom_range(0, 1));
      s.m2r_m       = 1'($urandom_range(0, 1));
      s.branch      = 1'($urandom_range(0, 1));
      s.pcsrc       = 1'($urandom_range(0, 1));
      s.hilo        = ($urandom_range(0, 3) == 0);
      s.mdstart_id  = ($urandom_range(0, 3) == 0);
      s.mdstart_ex  = ($urandom_range(0, 11) == 0);
      s.isdiv       = ($urandom_range(0, 3) == 0);
      cycle(s);
    end

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
